// File: rtl/fproc_pkg.sv
// fproc_pkg: shared definitions for the fproc request arbiter.
//   - fproc_state_e : arbiter FSM state encoding
//   - FPROC_ID_W / FPROC_DATA_W : default function-ID and response widths
//   - FPROC_ERR_DATA : response word returned to a core when the backend times out
package fproc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } fproc_state_e;

    localparam int unsigned FPROC_ID_W   = 8;
    localparam int unsigned FPROC_DATA_W = 32;

    localparam logic [FPROC_DATA_W-1:0] FPROC_ERR_DATA = '1;

endpackage

// File: rtl/fproc_rr_pick.sv
// fproc_rr_pick: combinational round-robin picker.
// Searches pending_i starting at rr_ptr_i and wrapping modulo N_CORES; reports
// the first set bit found.
//   pending_i [N_CORES] : per-core pending request flags
//   rr_ptr_i  [IDX_W]   : index the search starts from
//   grant_o   [IDX_W]   : index of the selected core (0 when valid_o is low)
//   valid_o             : at least one pending bit is set
module fproc_rr_pick
    import fproc_pkg::*;
#(
    parameter int unsigned N_CORES = 4,
    localparam int unsigned IDX_W  = $clog2(N_CORES)
) (
    input  logic [N_CORES-1:0] pending_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               valid_o
);

    always_comb begin
        int unsigned idx;
        grant_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N_CORES; k++) begin
            idx = (32'(rr_ptr_i) + k) % N_CORES;
            if (!valid_o && pending_i[idx]) begin
                valid_o = 1'b1;
                grant_o = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fproc_arbiter.sv
// fproc_arbiter: shares one fproc backend port between N_CORES cores.
// Each core's one-cycle request strobe is latched into a pending flag plus ID,
// requests are granted round-robin, issued to the backend one at a time, and
// the response is returned to the requesting core with a one-cycle ready strobe.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   core_req         : per-core request strobe
//   core_id          : per-core function ID, slice i belongs to core i
//   core_ready       : one-hot, one-cycle response strobe
//   core_data        : response data, held until the next response
//   fp_req_valid     : request to the backend (held until fp_req_accept)
//   fp_req_id        : ID of the granted request
//   fp_req_core      : index of the granted core
//   fp_req_accept    : backend accepts the request
//   fp_resp_valid    : backend response strobe (only honoured in WAIT_RESP)
//   fp_resp_data     : backend response data
//   fp_timeout       : one-cycle error strobe alongside core_ready
//                      (present only when FPROC_TIMEOUT_EN is defined)
//
// Build option: define FPROC_TIMEOUT_EN to abort a response wait after
// TIMEOUT_CYCLES cycles, returning FPROC_ERR_DATA to the core.
module fproc_arbiter
    import fproc_pkg::*;
#(
    parameter int unsigned N_CORES        = 4,
    parameter int unsigned ID_W           = FPROC_ID_W,
    parameter int unsigned DATA_W         = FPROC_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned IDX_W         = $clog2(N_CORES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CORES-1:0]      core_req,
    input  logic [N_CORES*ID_W-1:0] core_id,
    output logic [N_CORES-1:0]      core_ready,
    output logic [DATA_W-1:0]       core_data,
    output logic                    fp_req_valid,
    output logic [ID_W-1:0]         fp_req_id,
    output logic [IDX_W-1:0]        fp_req_core,
`ifdef FPROC_TIMEOUT_EN
    output logic                    fp_timeout,
`endif
    input  logic                    fp_req_accept,
    input  logic                    fp_resp_valid,
    input  logic [DATA_W-1:0]       fp_resp_data
);

    if (N_CORES < 2 || N_CORES > 16) begin : g_bad_n_cores
        $error("fproc_arbiter: N_CORES must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fproc_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    fproc_state_e        state_q, state_d;
    logic [N_CORES-1:0]  pending_q, pending_d;
    logic [ID_W-1:0]     id_q [N_CORES];
    logic [ID_W-1:0]     id_d [N_CORES];
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]     req_id_q, req_id_d;
    logic [DATA_W-1:0]   core_data_q, core_data_d;

    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic                grant_now;
    logic [N_CORES-1:0]  grant_clr;

    fproc_rr_pick #(
        .N_CORES (N_CORES)
    ) u_pick (
        .pending_i (pending_q),
        .rr_ptr_i  (rr_ptr_q),
        .grant_o   (pick_idx),
        .valid_o   (pick_valid)
    );

    assign grant_now = (state_q == IDLE) && pick_valid;
    assign grant_clr = grant_now ? (N_CORES'(1) << pick_idx) : '0;

    // Request capture. A strobe is taken when the slot is free, or when the
    // slot is being granted this same cycle (set wins over the grant clear).
    always_comb begin
        for (int unsigned i = 0; i < N_CORES; i++) begin
            logic take;
            take         = core_req[i] && (!pending_q[i] || grant_clr[i]);
            pending_d[i] = take || (pending_q[i] && !grant_clr[i]);
            id_d[i]      = take ? core_id[i*ID_W +: ID_W] : id_q[i];
        end
    end

`ifdef FPROC_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timed_out_q, timed_out_d;

    // Counts cycles spent in WAIT_RESP; zero on the entry cycle.
    assign tmo_cnt_d = (state_q == WAIT_RESP) ? tmo_cnt_q + 1'b1 : '0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        req_id_d    = req_id_q;
        core_data_d = core_data_q;
`ifdef FPROC_TIMEOUT_EN
        timed_out_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = ISSUE;
                    grant_d  = pick_idx;
                    req_id_d = id_q[pick_idx];
                    rr_ptr_d = (pick_idx == IDX_W'(N_CORES - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            ISSUE: begin
                if (fp_req_accept) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (fp_resp_valid) begin
                    core_data_d = fp_resp_data;
                    state_d     = DONE;
                end
`ifdef FPROC_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    core_data_d = '1;
                    timed_out_d = 1'b1;
                    state_d     = DONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            req_id_q    <= '0;
            core_data_q <= '0;
            for (int unsigned i = 0; i < N_CORES; i++) begin
                id_q[i] <= '0;
            end
`ifdef FPROC_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            req_id_q    <= req_id_d;
            core_data_q <= core_data_d;
            for (int unsigned i = 0; i < N_CORES; i++) begin
                id_q[i] <= id_d[i];
            end
`ifdef FPROC_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            timed_out_q <= timed_out_d;
`endif
        end
    end

    assign core_ready   = (state_q == DONE) ? (N_CORES'(1) << grant_q) : '0;
    assign core_data    = core_data_q;
    assign fp_req_valid = (state_q == ISSUE);
    assign fp_req_id    = req_id_q;
    assign fp_req_core  = grant_q;
`ifdef FPROC_TIMEOUT_EN
    // timed_out_q is only ever set for the DONE cycle that follows a timeout.
    assign fp_timeout   = timed_out_q;
`endif

endmodule

// File: tb/tb_fproc_arbiter.sv
// tb_fproc_arbiter: scoreboard bench for fproc_arbiter.
// The driver issues strobes and plays the backend; expected backend requests
// and core responses are queued from a round-robin reference model, and a
// separate monitor pops and compares whenever the DUT presents them.
module tb_fproc_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned IW  = 8;
    localparam int unsigned DW  = 32;
    localparam int unsigned IXW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    core_req;
    logic [N*IW-1:0] core_id;
    logic [N-1:0]    core_ready;
    logic [DW-1:0]   core_data;
    logic            fp_req_valid;
    logic [IW-1:0]   fp_req_id;
    logic [IXW-1:0]  fp_req_core;
    logic            fp_req_accept;
    logic            fp_resp_valid;
    logic [DW-1:0]   fp_resp_data;
`ifdef FPROC_TIMEOUT_EN
    logic            fp_timeout;
`endif

    fproc_arbiter #(
        .N_CORES        (N),
        .ID_W           (IW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .core_req      (core_req),
        .core_id       (core_id),
        .core_ready    (core_ready),
        .core_data     (core_data),
        .fp_req_valid  (fp_req_valid),
        .fp_req_id     (fp_req_id),
        .fp_req_core   (fp_req_core),
`ifdef FPROC_TIMEOUT_EN
        .fp_timeout    (fp_timeout),
`endif
        .fp_req_accept (fp_req_accept),
        .fp_resp_valid (fp_resp_valid),
        .fp_resp_data  (fp_resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   core;
        logic [IW-1:0] id;
    } req_t;

    typedef struct {
        int unsigned   core;
        logic [DW-1:0] data;
    } rdy_t;

    req_t        exp_req[$];
    rdy_t        exp_rdy[$];
    int unsigned checks   = 0;
    int unsigned passes   = 0;
    int unsigned model_rr = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic finish_bench();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    endtask

    // Advance to the next falling edge; all strobes default to one cycle.
    task automatic step();
        @(negedge clk);
        core_req      = '0;
        fp_req_accept = 1'b0;
        fp_resp_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok, output int unsigned n);
        ok = 1'b1;
        n  = 0;
        while (!fp_req_valid) begin
            if (n == 60) begin
                check("req_valid_wait", 64'(fp_req_valid), 64'(1));
                ok = 1'b0;
                return;
            end
            step();
            n++;
        end
    endtask

    // All cores in mask strobe together; served cyclically from model_rr.
    task automatic do_round(input logic [N-1:0] mask, input logic [N*IW-1:0] ids,
                            input logic [N*IW-1:0] dup_ids, input int acc_dly,
                            input int resp_dly, input bit dup_en, input bit stray_en,
                            input bit fixed_en, input logic [DW-1:0] fixed_data,
                            output bit ok);
        int unsigned order[$];
        int unsigned n;
        ok = 1'b1;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned c;
            c = (model_rr + k) % N;
            if (mask[c]) order.push_back(c);
        end
        step();
        for (int unsigned c = 0; c < N; c++) begin
            if (mask[c]) begin
                core_req[c]          = 1'b1;
                core_id[c*IW +: IW]  = ids[c*IW +: IW];
            end
        end
        foreach (order[j]) exp_req.push_back('{core: order[j], id: ids[order[j]*IW +: IW]});
        model_rr = (order[order.size()-1] + 1) % N;

        for (int unsigned j = 0; j < order.size(); j++) begin
            int unsigned   a;
            int unsigned   d;
            logic [DW-1:0] data;
            logic [N-1:0]  oh;
            a = (acc_dly < 0) ? $urandom_range(3) : acc_dly;
            d = (resp_dly < 0) ? $urandom_range(4) : resp_dly;
            step();
            wait_valid(ok, n);
            if (!ok) return;
            if (j == 0) check("first_issue_latency", 64'(n), 64'(1));
            else        check("b2b_issue_gap", 64'(n), 64'(0));
            for (int unsigned h = 0; h < a; h++) begin
                if (stray_en && h == 0) begin
                    fp_resp_valid = 1'b1;
                    fp_resp_data  = $urandom;
                end
                step();
            end
            fp_req_accept = 1'b1;
            step();
            check("valid_drop_after_accept", 64'(fp_req_valid), 64'(0));
            for (int unsigned w = 0; w < d; w++) begin
                if (dup_en && w == 0 && j + 1 < order.size()) begin
                    core_req[order[j+1]]           = 1'b1;
                    core_id[order[j+1]*IW +: IW]   = dup_ids[order[j+1]*IW +: IW];
                end
                step();
            end
            data = fixed_en ? fixed_data : $urandom;
            exp_rdy.push_back('{core: order[j], data: data});
            fp_resp_valid = 1'b1;
            fp_resp_data  = data;
            step();
            oh = '0;
            oh[order[j]] = 1'b1;
            check("ready_latency", 64'(core_ready), 64'(oh));
            step();
            check("ready_one_cycle", 64'(core_ready), 64'(0));
            check("data_hold", 64'(core_data), 64'(data));
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queue heads.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset !== 1'b1) begin
                if (fp_req_valid) begin
                    if (exp_req.size() == 0) begin
                        check("unexpected_req", 64'(fp_req_valid), 64'(0));
                    end else begin
                        check("req_core", 64'(fp_req_core), 64'(exp_req[0].core));
                        check("req_id", 64'(fp_req_id), 64'(exp_req[0].id));
                        if (fp_req_accept) void'(exp_req.pop_front());
                    end
                end
                if (core_ready != '0) begin
                    if (exp_rdy.size() == 0) begin
                        check("unexpected_ready", 64'(core_ready), 64'(0));
                    end else begin
                        rdy_t r;
                        logic [N-1:0] oh;
                        r = exp_rdy.pop_front();
                        oh = '0;
                        oh[r.core] = 1'b1;
                        check("ready_onehot", 64'(core_ready), 64'(oh));
                        check("ready_data", 64'(core_data), 64'(r.data));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int unsigned n;
        reset         = 1'b1;
        core_req      = '0;
        core_id       = '0;
        fp_req_accept = 1'b0;
        fp_resp_valid = 1'b0;
        fp_resp_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_core_ready", 64'(core_ready), 64'(0));
        check("rst_core_data", 64'(core_data), 64'(0));
        check("rst_req_valid", 64'(fp_req_valid), 64'(0));
        check("rst_req_id", 64'(fp_req_id), 64'(0));
        check("rst_req_core", 64'(fp_req_core), 64'(0));
        reset = 1'b0;

        // All four cores at once, then cores 0 and 3.
        do_round(4'b1111, 32'h44_33_22_11, '0, 0, 0, 1'b0, 1'b0, 1'b0, '0, ok);
        if (!ok) finish_bench();
        do_round(4'b1001, 32'h0A_00_00_0B, '0, 0, 0, 1'b0, 1'b0, 1'b0, '0, ok);
        if (!ok) finish_bench();

        // Single core 1, ID 0x21, accept at T+2, response at T+5.
        do_round(4'b0010, 32'h00_00_21_00, '0, 0, 2, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, ok);
        if (!ok) finish_bench();

        // Backpressure on core 3 with a stray response during ISSUE.
        do_round(4'b1000, 32'h77_00_00_00, '0, 10, 1, 1'b0, 1'b1, 1'b0, '0, ok);
        if (!ok) finish_bench();

        // Core 2 re-strobes ID 9 while its ID 5 request is still pending.
        do_round(4'b0101, 32'h00_05_00_66, 32'h00_09_00_00, 0, 3, 1'b1, 1'b0, 1'b0, '0, ok);
        if (!ok) finish_bench();
        repeat (4) begin
            step();
            check("no_dup_reissue", 64'(fp_req_valid), 64'(0));
        end

        // Reset while waiting for a response, with another core still pending.
        step();
        core_req[0] = 1'b1; core_id[0*IW +: IW] = 8'h30;
        core_req[1] = 1'b1; core_id[1*IW +: IW] = 8'h31;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned c;
            c = (model_rr + k) % N;
            if (c < 2) exp_req.push_back('{core: c, id: (c == 0) ? 8'h30 : 8'h31});
        end
        step();
        wait_valid(ok, n);
        if (!ok) finish_bench();
        fp_req_accept = 1'b1;
        step();
        reset = 1'b1;
        step();
        check("midrst_core_ready", 64'(core_ready), 64'(0));
        check("midrst_core_data", 64'(core_data), 64'(0));
        check("midrst_req_valid", 64'(fp_req_valid), 64'(0));
        check("midrst_req_id", 64'(fp_req_id), 64'(0));
        check("midrst_req_core", 64'(fp_req_core), 64'(0));
        exp_req.delete();
        exp_rdy.delete();
        model_rr = 0;
        reset = 1'b0;
        fp_resp_valid = 1'b1;
        fp_resp_data  = 32'h12345678;
        repeat (6) begin
            step();
            check("postrst_no_ready", 64'(core_ready), 64'(0));
            check("postrst_no_req", 64'(fp_req_valid), 64'(0));
        end

        // Randomized rounds.
        for (int unsigned r = 0; r < 40; r++) begin
            logic [N-1:0]    mask;
            logic [N*IW-1:0] ids;
            logic [N*IW-1:0] dups;
            mask = N'($urandom_range(1, (1 << N) - 1));
            ids  = $urandom;
            dups = $urandom;
            do_round(mask, ids, dups, -1, -1, bit'($urandom_range(1)),
                     bit'($urandom_range(1)), 1'b0, '0, ok);
            if (!ok) finish_bench();
        end

`ifdef FPROC_TIMEOUT_EN
        // No response: DONE after the 16th WAIT_RESP cycle with error data.
        begin
            int unsigned  c;
            logic [N-1:0] oh;
            c = 2;
            step();
            core_req[c] = 1'b1;
            core_id[c*IW +: IW] = 8'h5A;
            exp_req.push_back('{core: c, id: 8'h5A});
            model_rr = (c + 1) % N;
            step();
            wait_valid(ok, n);
            if (!ok) finish_bench();
            fp_req_accept = 1'b1;
            step();
            exp_rdy.push_back('{core: c, data: '1});
            repeat (15) step();
            check("tmo_not_early", 64'(core_ready), 64'(0));
            step();
            oh = '0;
            oh[c] = 1'b1;
            check("tmo_ready", 64'(core_ready), 64'(oh));
            check("tmo_data", 64'(core_data), 64'(32'hFFFF_FFFF));
            check("tmo_strobe", 64'(fp_timeout), 64'(1));
            fp_resp_valid = 1'b1;
            fp_resp_data  = 32'h0BAD_0BAD;
            step();
            check("tmo_strobe_clear", 64'(fp_timeout), 64'(0));
            repeat (3) begin
                step();
                check("tmo_late_ignored", 64'(core_ready), 64'(0));
            end
        end
`endif

        repeat (3) step();
        check("req_queue_drained", 64'(exp_req.size()), 64'(0));
        check("rdy_queue_drained", 64'(exp_rdy.size()), 64'(0));
        finish_bench();
    end

endmodule
